// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// mem_arbiter : grants the byte-serial memory controller to fetch, load/store
//               or prefetch with fixed priority, starvation relief and aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
   parameter int                ADDR_W       = 32,
   parameter int                DATA_W       = 32,
   parameter int                STARVE_LIMIT = 8,
   parameter logic [ADDR_W-1:0] IO_BASE      = 32'h30000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rdy,
   input  logic              flush,
   input  logic              uart_full,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_done,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              lsb_req,
   input  logic              lsb_we,
   input  logic [2:0]        lsb_width,
   input  logic [ADDR_W-1:0] lsb_addr,
   input  logic [DATA_W-1:0] lsb_wdata,
   output logic              lsb_done,
   output logic [DATA_W-1:0] lsb_rdata,
   input  logic              pf_req,
   input  logic [ADDR_W-1:0] pf_addr,
   output logic              pf_done,
   output logic [DATA_W-1:0] pf_rdata,
   output logic              mc_en,
   output logic              mc_we,
   output logic [2:0]        mc_width,
   output logic [ADDR_W-1:0] mc_addr,
   output logic [DATA_W-1:0] mc_wdata,
   input  logic              mc_ok,
   input  logic [DATA_W-1:0] mc_rdata
);

   localparam logic [1:0] c_ST_IDLE  = 2'd0;
   localparam logic [1:0] c_ST_BUSY  = 2'd1;
   localparam logic [1:0] c_ST_DRAIN = 2'd2;

   localparam logic [1:0] c_OWN_IF  = 2'd0;
   localparam logic [1:0] c_OWN_LSB = 2'd1;
   localparam logic [1:0] c_OWN_PF  = 2'd2;

   localparam logic [3:0]        c_LIMIT  = 4'(STARVE_LIMIT);
   localparam logic [2:0]        c_WORD   = 3'd4;
   localparam logic [ADDR_W-1:0] c_IO_END = IO_BASE + ADDR_W'(8);

   logic [1:0]        r_state, w_state_nxt;
   logic [1:0]        r_owner, w_owner_nxt;
   logic [3:0]        r_starve, w_starve_nxt;
   logic              r_ok, w_ok_nxt;
   logic              w_grant, w_capture;
   logic              w_io_wr, w_lsb_ok, w_if_ok, w_pf_ok, w_owner_req, w_abort;
   logic              r_we;
   logic [2:0]        r_width;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata, r_if_rdata, r_lsb_rdata, r_pf_rdata;

   assign w_io_wr  = lsb_we && (lsb_addr >= IO_BASE) && (lsb_addr < c_IO_END);
   assign w_lsb_ok = lsb_req && !(uart_full && w_io_wr);
   assign w_if_ok  = if_req && !flush;
   assign w_pf_ok  = pf_req && !flush;

   always_comb begin
      w_owner_req = 1'b0;
      case (r_owner)
         c_OWN_IF:  w_owner_req = if_req;
         c_OWN_LSB: w_owner_req = lsb_req;
         c_OWN_PF:  w_owner_req = pf_req;
         default:   w_owner_req = 1'b0;
      endcase
   end

   // Stores must complete, so flush only aborts fetch/prefetch ownership.
   assign w_abort = !w_owner_req || (flush && (r_owner != c_OWN_LSB));

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= c_ST_IDLE;
         r_owner     <= c_OWN_IF;
         r_starve    <= 4'd0;
         r_ok        <= 1'b0;
         r_we        <= 1'b0;
         r_width     <= 3'd0;
         r_addr      <= '0;
         r_wdata     <= '0;
         r_if_rdata  <= '0;
         r_lsb_rdata <= '0;
         r_pf_rdata  <= '0;
      end else if (rdy) begin
         r_state  <= w_state_nxt;
         r_owner  <= w_owner_nxt;
         r_starve <= w_starve_nxt;
         r_ok     <= w_ok_nxt;
         if (w_grant) begin
            r_we    <= (w_owner_nxt == c_OWN_LSB) ? lsb_we    : 1'b0;
            r_width <= (w_owner_nxt == c_OWN_LSB) ? lsb_width : c_WORD;
            r_wdata <= (w_owner_nxt == c_OWN_LSB) ? lsb_wdata : '0;
            case (w_owner_nxt)
               c_OWN_LSB: r_addr <= lsb_addr;
               c_OWN_PF:  r_addr <= pf_addr;
               default:   r_addr <= if_addr;
            endcase
         end
         if (w_capture) begin
            case (r_owner)
               c_OWN_LSB: r_lsb_rdata <= mc_rdata;
               c_OWN_PF:  r_pf_rdata  <= mc_rdata;
               default:   r_if_rdata  <= mc_rdata;
            endcase
         end
      end
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_owner_nxt  = r_owner;
      w_starve_nxt = r_starve;
      w_ok_nxt     = r_ok;
      w_grant      = 1'b0;
      w_capture    = 1'b0;
      case (r_state)
         c_ST_IDLE: begin
            w_ok_nxt = 1'b0;
            if (w_if_ok && (r_starve == c_LIMIT)) begin
               w_grant     = 1'b1;
               w_owner_nxt = c_OWN_IF;
            end else if (w_lsb_ok) begin
               w_grant     = 1'b1;
               w_owner_nxt = c_OWN_LSB;
            end else if (w_if_ok) begin
               w_grant     = 1'b1;
               w_owner_nxt = c_OWN_IF;
            end else if (w_pf_ok) begin
               w_grant     = 1'b1;
               w_owner_nxt = c_OWN_PF;
            end
            if (w_grant)
               w_state_nxt = c_ST_BUSY;
            if (!if_req)
               w_starve_nxt = 4'd0;
            else if (w_grant && (w_owner_nxt == c_OWN_IF))
               w_starve_nxt = 4'd0;
            else if (w_grant && (w_owner_nxt == c_OWN_LSB) && (r_starve != c_LIMIT))
               w_starve_nxt = r_starve + 4'd1;
         end
         c_ST_BUSY: begin
            // Abort is checked first so a coincident flush suppresses completion.
            if (w_abort) begin
               w_state_nxt = c_ST_DRAIN;
               w_ok_nxt    = 1'b0;
            end else if (mc_ok) begin
               w_state_nxt = c_ST_DRAIN;
               w_ok_nxt    = 1'b1;
               w_capture   = 1'b1;
            end
         end
         c_ST_DRAIN: w_state_nxt = c_ST_IDLE;
         default:    w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      mc_en     = (r_state == c_ST_BUSY);
      mc_we     = r_we;
      mc_width  = r_width;
      mc_addr   = r_addr;
      mc_wdata  = r_wdata;
      if_done   = (r_state == c_ST_DRAIN) && r_ok && (r_owner == c_OWN_IF);
      lsb_done  = (r_state == c_ST_DRAIN) && r_ok && (r_owner == c_OWN_LSB);
      pf_done   = (r_state == c_ST_DRAIN) && r_ok && (r_owner == c_OWN_PF);
      if_rdata  = r_if_rdata;
      lsb_rdata = r_lsb_rdata;
      pf_rdata  = r_pf_rdata;
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_arbiter : directed self-checking bench for mem_arbiter.
// Revision       : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, uart_full;
   logic        if_req, lsb_req, lsb_we, pf_req, mc_ok;
   logic [2:0]  lsb_width;
   logic [31:0] if_addr, lsb_addr, lsb_wdata, pf_addr, mc_rdata;
   logic        if_done, lsb_done, pf_done, mc_en, mc_we;
   logic [2:0]  mc_width;
   logic [31:0] if_rdata, lsb_rdata, pf_rdata, mc_addr, mc_wdata;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_if = 32'h0;

   mem_arbiter dut (
      .clk(clk), .rst(rst), .rdy(rdy), .flush(flush), .uart_full(uart_full),
      .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
      .lsb_req(lsb_req), .lsb_we(lsb_we), .lsb_width(lsb_width), .lsb_addr(lsb_addr),
      .lsb_wdata(lsb_wdata), .lsb_done(lsb_done), .lsb_rdata(lsb_rdata),
      .pf_req(pf_req), .pf_addr(pf_addr), .pf_done(pf_done), .pf_rdata(pf_rdata),
      .mc_en(mc_en), .mc_we(mc_we), .mc_width(mc_width), .mc_addr(mc_addr),
      .mc_wdata(mc_wdata), .mc_ok(mc_ok), .mc_rdata(mc_rdata)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ok_pulse(input logic [31:0] data);
      mc_rdata = data;
      mc_ok    = 1'b1;
      tick();
      mc_ok    = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b0; rdy = 1'b1; flush = 1'b0; uart_full = 1'b0; mc_ok = 1'b0;
      if_req = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0; pf_req = 1'b0;
      lsb_width = 3'd0; if_addr = '0; lsb_addr = '0; lsb_wdata = '0; pf_addr = '0;
      mc_rdata = '0;
      tick(); tick();
      checks++;
      if ({mc_en, mc_we, mc_width, if_done, lsb_done, pf_done} !== 8'h00) begin
         errors++; $display("FAIL reset_ctrl: got %b want 0", {mc_en, mc_we, mc_width, if_done, lsb_done, pf_done});
      end
      checks++;
      if ({if_rdata, lsb_rdata, pf_rdata, mc_addr, mc_wdata} !== 160'h0) begin
         errors++; $display("FAIL reset_data: got %h want 0", {if_rdata, lsb_rdata, pf_rdata, mc_addr, mc_wdata});
      end
      rst = 1'b1;
      tick();
   endtask

   task automatic test_fetch();
      if_req = 1'b1; if_addr = 32'h100;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_width, mc_addr} !== {1'b1, 1'b0, 3'd4, 32'h100}) begin
         errors++; $display("FAIL fetch_issue: got en=%b we=%b w=%0d a=%h want 1 0 4 100", mc_en, mc_we, mc_width, mc_addr);
      end
      ok_pulse(32'hDEADBEEF);
      checks++;
      if ({if_done, mc_en, if_rdata} !== {1'b1, 1'b0, 32'hDEADBEEF}) begin
         errors++; $display("FAIL fetch_done: got done=%b en=%b d=%h want 1 0 deadbeef", if_done, mc_en, if_rdata);
      end
      exp_if = 32'hDEADBEEF;
      if_req = 1'b0;
      tick();
      checks++;
      if ({if_done, mc_en, if_rdata} !== {1'b0, 1'b0, exp_if}) begin
         errors++; $display("FAIL fetch_idle: got done=%b en=%b d=%h want 0 0 %h", if_done, mc_en, if_rdata, exp_if);
      end
   endtask

   task automatic test_priority();
      if_req = 1'b1; if_addr = 32'h104;
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd2; lsb_addr = 32'h2000;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_width, mc_addr} !== {1'b1, 1'b0, 3'd2, 32'h2000}) begin
         errors++; $display("FAIL prio_lsb: got en=%b we=%b w=%0d a=%h want 1 0 2 2000", mc_en, mc_we, mc_width, mc_addr);
      end
      ok_pulse(32'h00001234);
      checks++;
      if ({lsb_done, if_done, lsb_rdata} !== {1'b1, 1'b0, 32'h1234}) begin
         errors++; $display("FAIL prio_lsb_done: got l=%b i=%b d=%h want 1 0 1234", lsb_done, if_done, lsb_rdata);
      end
      lsb_req = 1'b0;
      tick();
      checks++;
      if (mc_en !== 1'b0) begin
         errors++; $display("FAIL prio_bubble: got mc_en=%b want 0", mc_en);
      end
      tick();
      checks++;
      if ({mc_en, mc_width, mc_addr} !== {1'b1, 3'd4, 32'h104}) begin
         errors++; $display("FAIL prio_if: got en=%b w=%0d a=%h want 1 4 104", mc_en, mc_width, mc_addr);
      end
      ok_pulse(32'h11111111);
      exp_if = 32'h11111111;
      checks++;
      if ({if_done, if_rdata} !== {1'b1, exp_if}) begin
         errors++; $display("FAIL prio_if_done: got %b %h want 1 %h", if_done, if_rdata, exp_if);
      end
      if_req = 1'b0;
      tick();
   endtask

   task automatic test_starvation();
      if_req = 1'b1;
      lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd4; lsb_addr = 32'h3000;
      for (int r = 0; r < 2; r++) begin
         if_addr = 32'h200 + 32'(r * 4);
         for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({mc_en, mc_addr} !== {1'b1, 32'h3000}) begin
               errors++; $display("FAIL starve_lsb r%0d i%0d: got en=%b a=%h want 1 3000", r, i, mc_en, mc_addr);
            end
            ok_pulse(32'hA0000000 + 32'(i));
            checks++;
            if ({lsb_done, lsb_rdata} !== {1'b1, 32'hA0000000 + 32'(i)}) begin
               errors++; $display("FAIL starve_lsb_done r%0d i%0d: got %b %h want 1 %h", r, i, lsb_done, lsb_rdata, 32'hA0000000 + 32'(i));
            end
            tick();
         end
         tick();
         checks++;
         if ({mc_en, mc_width, mc_addr} !== {1'b1, 3'd4, if_addr}) begin
            errors++; $display("FAIL starve_if r%0d: got en=%b w=%0d a=%h want 1 4 %h", r, mc_en, mc_width, mc_addr, if_addr);
         end
         ok_pulse(32'hC0DE0000 + 32'(r));
         exp_if = 32'hC0DE0000 + 32'(r);
         checks++;
         if ({if_done, if_rdata} !== {1'b1, exp_if}) begin
            errors++; $display("FAIL starve_if_done r%0d: got %b %h want 1 %h", r, if_done, if_rdata, exp_if);
         end
         if (r == 1) begin
            if_req = 1'b0; lsb_req = 1'b0;
         end
         tick();
      end
   endtask

   task automatic test_io_backpressure();
      if_req = 1'b1; if_addr = 32'h300;
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd1; lsb_addr = 32'h30000; lsb_wdata = 32'hA5;
      uart_full = 1'b1;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_addr} !== {1'b1, 1'b0, 32'h300}) begin
         errors++; $display("FAIL io_if_first: got en=%b we=%b a=%h want 1 0 300", mc_en, mc_we, mc_addr);
      end
      ok_pulse(32'h33333333);
      exp_if = 32'h33333333;
      if_req = 1'b0;
      tick();
      tick();
      checks++;
      if (mc_en !== 1'b0) begin
         errors++; $display("FAIL io_held: got mc_en=%b want 0", mc_en);
      end
      uart_full = 1'b0;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_width, mc_addr, mc_wdata} !== {1'b1, 1'b1, 3'd1, 32'h30000, 32'hA5}) begin
         errors++; $display("FAIL io_store: got en=%b we=%b w=%0d a=%h d=%h want 1 1 1 30000 a5", mc_en, mc_we, mc_width, mc_addr, mc_wdata);
      end
      ok_pulse(32'h0);
      checks++;
      if (lsb_done !== 1'b1) begin
         errors++; $display("FAIL io_store_done: got %b want 1", lsb_done);
      end
      lsb_req = 1'b0; lsb_we = 1'b0;
      tick();
   endtask

   task automatic test_flush();
      pf_req = 1'b1; pf_addr = 32'h400;
      tick();
      checks++;
      if ({mc_en, mc_width, mc_addr} !== {1'b1, 3'd4, 32'h400}) begin
         errors++; $display("FAIL pf_issue: got en=%b w=%0d a=%h want 1 4 400", mc_en, mc_width, mc_addr);
      end
      tick();
      flush = 1'b1;
      tick();
      checks++;
      if ({mc_en, pf_done} !== 2'b00) begin
         errors++; $display("FAIL pf_flush: got en=%b done=%b want 0 0", mc_en, pf_done);
      end
      flush = 1'b0; pf_req = 1'b0;
      tick();
      checks++;
      if ({mc_en, pf_done, pf_rdata} !== {2'b00, 32'h0}) begin
         errors++; $display("FAIL pf_flush_idle: got en=%b done=%b d=%h want 0 0 0", mc_en, pf_done, pf_rdata);
      end
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd4; lsb_addr = 32'h2004; lsb_wdata = 32'h55AA55AA;
      tick();
      flush = 1'b1;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_wdata} !== {2'b11, 32'h55AA55AA}) begin
         errors++; $display("FAIL lsb_flush_kept: got en=%b we=%b d=%h want 1 1 55aa55aa", mc_en, mc_we, mc_wdata);
      end
      ok_pulse(32'h0BADF00D);
      checks++;
      if ({lsb_done, lsb_rdata} !== {1'b1, 32'h0BADF00D}) begin
         errors++; $display("FAIL lsb_flush_done: got %b %h want 1 0badf00d", lsb_done, lsb_rdata);
      end
      flush = 1'b0; lsb_req = 1'b0; lsb_we = 1'b0;
      tick();
   endtask

   task automatic test_ok_flush();
      if_req = 1'b1; if_addr = 32'h500;
      tick();
      flush = 1'b1;
      ok_pulse(32'hBAD0BAD0);
      checks++;
      if ({if_done, mc_en, if_rdata} !== {2'b00, exp_if}) begin
         errors++; $display("FAIL ok_flush: got done=%b en=%b d=%h want 0 0 %h", if_done, mc_en, if_rdata, exp_if);
      end
      flush = 1'b0; if_req = 1'b0;
      tick();
   endtask

   task automatic test_rdy();
      if_req = 1'b1; if_addr = 32'h600;
      tick();
      ok_pulse(32'h600DF00D);
      exp_if = 32'h600DF00D;
      rdy = 1'b0;
      tick(); tick();
      checks++;
      if ({if_done, mc_en, if_rdata} !== {2'b10, exp_if}) begin
         errors++; $display("FAIL rdy_stretch: got done=%b en=%b d=%h want 1 0 %h", if_done, mc_en, if_rdata, exp_if);
      end
      rdy = 1'b1; if_req = 1'b0;
      tick();
      checks++;
      if (if_done !== 1'b0) begin
         errors++; $display("FAIL rdy_release: got %b want 0", if_done);
      end
      rdy = 1'b0; lsb_req = 1'b1; lsb_we = 1'b0; lsb_width = 3'd4; lsb_addr = 32'h700;
      tick();
      checks++;
      if (mc_en !== 1'b0) begin
         errors++; $display("FAIL rdy_frozen: got mc_en=%b want 0", mc_en);
      end
      rdy = 1'b1;
      tick();
      checks++;
      if ({mc_en, mc_addr} !== {1'b1, 32'h700}) begin
         errors++; $display("FAIL rdy_resume: got en=%b a=%h want 1 700", mc_en, mc_addr);
      end
      ok_pulse(32'h77);
      lsb_req = 1'b0;
      tick();
   endtask

   task automatic test_reset_busy();
      lsb_req = 1'b1; lsb_we = 1'b1; lsb_width = 3'd4; lsb_addr = 32'h2008; lsb_wdata = 32'h12345678;
      tick();
      checks++;
      if (mc_en !== 1'b1) begin
         errors++; $display("FAIL rstbusy_issue: got %b want 1", mc_en);
      end
      rst = 1'b0;
      tick();
      checks++;
      if ({mc_en, mc_we, mc_width, if_done, lsb_done, pf_done} !== 8'h00) begin
         errors++; $display("FAIL rstbusy_ctrl: got %b want 0", {mc_en, mc_we, mc_width, if_done, lsb_done, pf_done});
      end
      checks++;
      if ({if_rdata, lsb_rdata, pf_rdata, mc_addr, mc_wdata} !== 160'h0) begin
         errors++; $display("FAIL rstbusy_data: got %h want 0", {if_rdata, lsb_rdata, pf_rdata, mc_addr, mc_wdata});
      end
      rst = 1'b1; lsb_req = 1'b0; lsb_we = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_priority();
      test_starvation();
      test_io_backpressure();
      test_flush();
      test_ok_flush();
      test_rdy();
      test_reset_busy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
